// File: rtl/bp_pkg.sv
// Shared definitions for the branch resolution path: 2-bit counter encoding,
// counter update rule and prediction-entry layout.
package bp_pkg;

   localparam logic [1:0] STRONG_NT = 2'b00;
   localparam logic [1:0] WEAK_NT   = 2'b01;
   localparam logic [1:0] WEAK_T    = 2'b10;
   localparam logic [1:0] STRONG_T  = 2'b11;

   localparam int unsigned ST_W   = 2;
   localparam int unsigned PRED_W = 1;

   // Saturating counter step toward the observed direction.
   function automatic logic [1:0] bp_next_state(input logic [1:0] state, input logic taken);
      logic [1:0] nxt;
      nxt = state;
      if (taken) begin
         if (state != STRONG_T) nxt = state + 2'd1;
      end else begin
         if (state != STRONG_NT) nxt = state - 2'd1;
      end
      return nxt;
   endfunction

   // Entry layout, MSB to LSB: {pc, idx, state, pred, target}.
   function automatic int unsigned bp_entry_w(input int unsigned xlen, input int unsigned idx_w);
      return 2 * xlen + idx_w + ST_W + PRED_W;
   endfunction

endpackage

// File: rtl/bp_pred_fifo.sv
// Circular buffer of in-flight branch predictions with a synchronous clear
// that wins over any push or pop in the same cycle.
module bp_pred_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 72
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Power-of-two depth lets the pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clr) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves the oldest in-flight branch prediction against execute's outcome,
// emitting the BHT counter write-back, mispredict flush/redirect and statistics.
module branch_resolve_unit
   import bp_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned IDX_W = 5,
   parameter int unsigned XLEN  = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push_valid,
   output logic                    push_ready,
   input  logic [XLEN-1:0]         push_pc,
   input  logic [IDX_W-1:0]        push_idx,
   input  logic [1:0]              push_state,
   input  logic                    push_pred,
   input  logic [XLEN-1:0]         push_target,
   input  logic                    res_valid,
   input  logic                    res_taken,
   input  logic [XLEN-1:0]         res_target,
   output logic                    upd_en,
   output logic [IDX_W-1:0]        upd_idx,
   output logic [1:0]              upd_state,
   output logic                    flush,
   output logic [XLEN-1:0]         redirect_pc,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    err,
   output logic [15:0]             branch_cnt,
   output logic [15:0]             mispred_cnt
);

   localparam int unsigned EW       = bp_entry_w(XLEN, IDX_W);
   localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;
   localparam int unsigned PRED_BIT = XLEN;
   localparam int unsigned ST_LSB   = XLEN + PRED_W;
   localparam int unsigned IDX_LSB  = ST_LSB + ST_W;
   localparam int unsigned PC_LSB   = IDX_LSB + IDX_W;

   logic [EW-1:0]    wr_entry, head;
   logic [CNT_W-1:0] fifo_count;
   logic [XLEN-1:0]  h_pc, h_target;
   logic [IDX_W-1:0] h_idx;
   logic [1:0]       h_state;
   logic             h_pred;
   logic             res_fire, mispred, push_fire;

   logic             upd_en_q, upd_en_d;
   logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
   logic [1:0]       upd_state_q, upd_state_d;
   logic             flush_q, flush_d;
   logic [XLEN-1:0]  redirect_q, redirect_d;
   logic             err_q, err_d;
   logic [15:0]      branch_cnt_q, branch_cnt_d;
   logic [15:0]      mispred_cnt_q, mispred_cnt_d;

   assign wr_entry = {push_pc, push_idx, push_state, push_pred, push_target};
   assign h_target = head[XLEN-1:0];
   assign h_pred   = head[PRED_BIT];
   assign h_state  = head[ST_LSB +: ST_W];
   assign h_idx    = head[IDX_LSB +: IDX_W];
   assign h_pc     = head[PC_LSB +: XLEN];

   assign push_ready = (fifo_count < CNT_W'(DEPTH));
   assign res_fire   = res_valid && (fifo_count != '0);
   assign mispred    = res_fire &&
                       ((h_pred != res_taken) || (h_pred && res_taken && (h_target != res_target)));
   // Pushes are dropped both in the mispredict cycle and while the flush pulse is out.
   assign push_fire  = push_valid && push_ready && !mispred && !flush_q;

   bp_pred_fifo #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (mispred),
      .push  (push_fire),
      .pop   (res_fire),
      .wdata (wr_entry),
      .rdata (head),
      .count (fifo_count)
   );

   always_comb begin
      upd_en_d      = res_fire;
      upd_idx_d     = upd_idx_q;
      upd_state_d   = upd_state_q;
      flush_d       = mispred;
      redirect_d    = redirect_q;
      err_d         = err_q | (res_valid && !res_fire);
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (res_fire) begin
         upd_idx_d   = h_idx;
         upd_state_d = bp_next_state(h_state, res_taken);
         if (branch_cnt_q != 16'hFFFF) branch_cnt_d = branch_cnt_q + 16'd1;
      end
      if (mispred) begin
         redirect_d = res_taken ? res_target : h_pc + XLEN'(4);
         if (mispred_cnt_q != 16'hFFFF) mispred_cnt_d = mispred_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         upd_en_q      <= 1'b0;
         upd_idx_q     <= '0;
         upd_state_q   <= STRONG_NT;
         flush_q       <= 1'b0;
         redirect_q    <= '0;
         err_q         <= 1'b0;
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         upd_en_q      <= upd_en_d;
         upd_idx_q     <= upd_idx_d;
         upd_state_q   <= upd_state_d;
         flush_q       <= flush_d;
         redirect_q    <= redirect_d;
         err_q         <= err_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign upd_en      = upd_en_q;
   assign upd_idx     = upd_idx_q;
   assign upd_state   = upd_state_q;
   assign flush       = flush_q;
   assign redirect_pc = redirect_q;
   assign count       = fifo_count;
   assign err         = err_q;
   assign branch_cnt  = branch_cnt_q;
   assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus random
// traffic, all checked against a queue-based model of in-flight predictions.
module tb_branch_resolve_unit;

   localparam int DEPTH = 4;
   localparam int IDX_W = 5;
   localparam int XLEN  = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              push_valid = 1'b0;
   logic              push_ready;
   logic [XLEN-1:0]   push_pc = '0;
   logic [IDX_W-1:0]  push_idx = '0;
   logic [1:0]        push_state = '0;
   logic              push_pred = 1'b0;
   logic [XLEN-1:0]   push_target = '0;
   logic              res_valid = 1'b0;
   logic              res_taken = 1'b0;
   logic [XLEN-1:0]   res_target = '0;
   logic              upd_en;
   logic [IDX_W-1:0]  upd_idx;
   logic [1:0]        upd_state;
   logic              flush;
   logic [XLEN-1:0]   redirect_pc;
   logic [$clog2(DEPTH):0] count;
   logic              err;
   logic [15:0]       branch_cnt;
   logic [15:0]       mispred_cnt;

   always #5 clk = ~clk;

   branch_resolve_unit #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W),
      .XLEN  (XLEN)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_valid  (push_valid),
      .push_ready  (push_ready),
      .push_pc     (push_pc),
      .push_idx    (push_idx),
      .push_state  (push_state),
      .push_pred   (push_pred),
      .push_target (push_target),
      .res_valid   (res_valid),
      .res_taken   (res_taken),
      .res_target  (res_target),
      .upd_en      (upd_en),
      .upd_idx     (upd_idx),
      .upd_state   (upd_state),
      .flush       (flush),
      .redirect_pc (redirect_pc),
      .count       (count),
      .err         (err),
      .branch_cnt  (branch_cnt),
      .mispred_cnt (mispred_cnt)
   );

   int checks = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: a queue of outstanding predictions plus expected outputs.
   typedef struct {
      logic [31:0] pc;
      logic [4:0]  idx;
      logic [1:0]  st;
      logic        pred;
      logic [31:0] tgt;
   } ent_t;

   ent_t        mq[$];
   bit          m_err;
   int          m_branch, m_mispred;
   bit          e_upd_en, e_flush;
   logic [4:0]  e_idx;
   logic [1:0]  e_state;
   logic [31:0] e_redirect;

   function automatic logic [1:0] counter_step(input logic [1:0] st, input logic taken);
      int v;
      v = int'(st) + (taken ? 1 : -1);
      if (v > 3) v = 3;
      if (v < 0) v = 0;
      return 2'(v);
   endfunction

   task automatic model_reset();
      mq.delete();
      m_err = 0;
      m_branch = 0;
      m_mispred = 0;
      e_upd_en = 0;
      e_flush = 0;
   endtask

   task automatic check_reset_values();
      check_eq("rst_count", 32'(count), 0);
      check_eq("rst_push_ready", 32'(push_ready), 1);
      check_eq("rst_upd_en", 32'(upd_en), 0);
      check_eq("rst_upd_idx", 32'(upd_idx), 0);
      check_eq("rst_upd_state", 32'(upd_state), 0);
      check_eq("rst_flush", 32'(flush), 0);
      check_eq("rst_redirect", redirect_pc, 0);
      check_eq("rst_err", 32'(err), 0);
      check_eq("rst_branch_cnt", 32'(branch_cnt), 0);
      check_eq("rst_mispred_cnt", 32'(mispred_cnt), 0);
   endtask

   // Applies current inputs for one clock and checks the registered result.
   task automatic step();
      ent_t h, n;
      bit   ready, mis, fire;
      ready = mq.size() < DEPTH;
      check_eq("count", 32'(count), 32'(mq.size()));
      check_eq("push_ready", 32'(push_ready), 32'(ready));
      mis = 0;
      fire = 0;
      if (res_valid) begin
         if (mq.size() == 0) begin
            m_err = 1;
         end else begin
            h = mq.pop_front();
            fire = 1;
            mis = (h.pred != res_taken) || (h.pred && res_taken && h.tgt != res_target);
            e_idx = h.idx;
            e_state = counter_step(h.st, res_taken);
            if (m_branch < 65535) m_branch++;
            if (mis) begin
               e_redirect = res_taken ? res_target : h.pc + 32'd4;
               mq.delete();
               if (m_mispred < 65535) m_mispred++;
            end
         end
      end
      if (push_valid && ready && !mis && !e_flush) begin
         n.pc = push_pc;
         n.idx = push_idx;
         n.st = push_state;
         n.pred = push_pred;
         n.tgt = push_target;
         mq.push_back(n);
      end
      e_upd_en = fire;
      e_flush = mis;
      @(posedge clk);
      #1;
      check_eq("upd_en", 32'(upd_en), 32'(e_upd_en));
      check_eq("flush", 32'(flush), 32'(e_flush));
      check_eq("err", 32'(err), 32'(m_err));
      check_eq("branch_cnt", 32'(branch_cnt), 32'(m_branch));
      check_eq("mispred_cnt", 32'(mispred_cnt), 32'(m_mispred));
      if (e_upd_en) begin
         check_eq("upd_idx", 32'(upd_idx), 32'(e_idx));
         check_eq("upd_state", 32'(upd_state), 32'(e_state));
      end
      if (e_flush) check_eq("redirect_pc", redirect_pc, e_redirect);
   endtask

   task automatic set_push(input logic [31:0] pc, input logic [4:0] idx, input logic [1:0] st,
                           input logic pred, input logic [31:0] tgt);
      push_valid = 1'b1;
      push_pc = pc;
      push_idx = idx;
      push_state = st;
      push_pred = pred;
      push_target = tgt;
   endtask

   task automatic set_res(input logic taken, input logic [31:0] tgt);
      res_valid = 1'b1;
      res_taken = taken;
      res_target = tgt;
   endtask

   task automatic idle();
      push_valid = 1'b0;
      res_valid = 1'b0;
   endtask

   task automatic apply_reset();
      idle();
      #2 rst_n = 1'b0;
      #1 check_reset_values();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      model_reset();
      #3 check_reset_values();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Weak-NT predicted not-taken, resolves taken.
      set_push(32'h100, 5'd3, 2'b01, 1'b0, 32'h0); step();
      idle(); set_res(1'b1, 32'h200); step();
      check_eq("tp1_upd_idx", 32'(upd_idx), 3);
      check_eq("tp1_upd_state", 32'(upd_state), 2);
      check_eq("tp1_redirect", redirect_pc, 32'h200);
      check_eq("tp1_mispred_cnt", 32'(mispred_cnt), 1);
      idle(); step();

      // Correct taken prediction, then a wrong-target one.
      set_push(32'h300, 5'd7, 2'b11, 1'b1, 32'h40); step();
      idle(); set_res(1'b1, 32'h40); step();
      check_eq("tp2_flush", 32'(flush), 0);
      check_eq("tp2_upd_state", 32'(upd_state), 3);
      set_push(32'h304, 5'd7, 2'b11, 1'b1, 32'h40); step();
      idle(); set_res(1'b1, 32'h44); step();
      check_eq("tp2_tgt_flush", 32'(flush), 1);
      check_eq("tp2_tgt_redirect", redirect_pc, 32'h44);
      idle(); step();

      // Fill, push while full, mispredict head with a simultaneous push.
      for (int i = 0; i < DEPTH; i++) begin
         set_push(32'h1000 + 32'(i * 4), 5'(i), 2'b10, 1'b1, 32'h80);
         step();
      end
      check_eq("full_ready", 32'(push_ready), 0);
      set_push(32'h2000, 5'd9, 2'b10, 1'b1, 32'h80); step();
      set_res(1'b0, 32'h0); step();
      check_eq("flush_count", 32'(count), 0);
      check_eq("flush_ready", 32'(push_ready), 1);
      idle(); step();

      // Resolution with nothing outstanding.
      set_res(1'b1, 32'h10); step();
      idle(); step(); step();
      check_eq("err_sticky", 32'(err), 1);
      apply_reset();

      // Redirect wrap and counter floor.
      set_push(32'hFFFF_FFFC, 5'd31, 2'b10, 1'b1, 32'h8); step();
      idle(); set_res(1'b0, 32'h0); step();
      check_eq("wrap_redirect", redirect_pc, 0);
      check_eq("wrap_upd_state", 32'(upd_state), 1);
      idle(); step();
      set_push(32'h500, 5'd4, 2'b00, 1'b0, 32'h0); step();
      idle(); set_res(1'b0, 32'h0); step();
      check_eq("floor_upd_state", 32'(upd_state), 0);
      check_eq("floor_flush", 32'(flush), 0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [1:0] st;
         st = 2'($urandom_range(0, 3));
         push_valid = ($urandom_range(0, 99) < 60);
         push_pc = {$urandom_range(0, 32'hFFFF), 2'b00};
         push_idx = 5'($urandom_range(0, 31));
         push_state = st;
         push_pred = ($urandom_range(0, 9) == 0) ? ~st[1] : st[1];
         push_target = ($urandom_range(0, 1) == 1) ? 32'h40 : 32'h44;
         res_valid = ($urandom_range(0, 99) < 45);
         res_taken = 1'($urandom_range(0, 1));
         res_target = ($urandom_range(0, 3) == 0) ? 32'h44 : 32'h40;
         step();
      end
      idle(); step();

      // Asynchronous reset with three entries outstanding and an update pulse live.
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         set_push(32'h600 + 32'(i * 4), 5'(i), 2'b11, 1'b1, 32'h40);
         step();
      end
      set_push(32'h700, 5'd8, 2'b11, 1'b1, 32'h40); set_res(1'b1, 32'h40); step();
      check_eq("pre_rst_upd_en", 32'(upd_en), 1);
      apply_reset();
      check_eq("post_rst_count", 32'(count), 0);

      // Branch counter saturation: one resolution per cycle with a refill each cycle.
      set_push(32'h800, 5'd2, 2'b11, 1'b1, 32'h40); step();
      set_res(1'b1, 32'h40);
      for (int i = 0; i < 65540; i++) step();
      check_eq("sat_branch_cnt", 32'(branch_cnt), 32'hFFFF);
      idle(); step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
